// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register arbiter with force override.
package reg_arb_pkg;

  // Top-level control state: normal arbitration or externally forced value.
  typedef enum logic {
    StRun    = 1'b0,
    StForced = 1'b1
  } arb_state_e;

  // Pointer width; keeps a 1-bit pointer for the degenerate single-requester case.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_override_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned PtrW = ptr_width(N)
) (
  input  logic [N-1:0]    eligible_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic            found_o,
  output logic [PtrW-1:0] idx_o,
  output logic [N-1:0]    onehot_o
);

  int unsigned cand;
  logic        hit;

  // Scan N candidates starting at ptr; the first eligible one wins.
  always_comb begin
    cand     = 0;
    hit      = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = (32'(ptr_i) + off) % N;
      if (!hit && eligible_i[cand]) begin
        hit   = 1'b1;
        idx_o = PtrW'(cand);
      end
    end
    onehot_o[idx_o] = hit;
    found_o         = hit;
  end

endmodule

// File: rtl/reg_override_arbiter.sv
// One W-bit register shared by N round-robin writers, with a force/release override.
module reg_override_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned W            = 8,
  parameter int unsigned RELEASE_KEEP = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] wdata_i,
  input  logic           force_en_i,
  input  logic [W-1:0]   force_val_i,
  output logic [N-1:0]   grant_o,
  output logic [W-1:0]   q_o,
  output logic           q_valid_o,
  output logic           forced_o
);

  localparam int unsigned PtrW = ptr_width(N);

  arb_state_e      state_q;
  logic [W-1:0]    stored_q;
  logic [W-1:0]    q_q;
  logic [PtrW-1:0] ptr_q;
  logic [N-1:0]    grant_q;
  logic            q_valid_q;

  logic [W-1:0]    wdata_lane [N];
  logic [N-1:0]    eligible;
  logic            pick_found;
  logic [PtrW-1:0] pick_idx;
  logic [N-1:0]    pick_onehot;
  logic [PtrW-1:0] ptr_next;

  // Unpack the flat write-data bus into per-requester lanes.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      wdata_lane[i] = wdata_i[i*W +: W];
    end
  end

  // A requester granted last edge is masked so its still-high req cannot write twice.
  assign eligible = req_i & ~grant_q;

  rr_pick #(
    .N(N)
  ) u_pick (
    .eligible_i(eligible),
    .ptr_i     (ptr_q),
    .found_o   (pick_found),
    .idx_o     (pick_idx),
    .onehot_o  (pick_onehot)
  );

  // Pointer moves just past the winner, wrapping at N-1.
  always_comb begin
    ptr_next = (pick_idx == PtrW'(N - 1)) ? '0 : pick_idx + 1'b1;
  end

  // Control FSM plus all datapath registers; reset aborts any force or grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StRun;
      stored_q  <= '0;
      q_q       <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      q_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (force_en_i) begin
            // Force takes priority over any pending request on this edge.
            state_q   <= StForced;
            q_q       <= force_val_i;
            grant_q   <= '0;
            q_valid_q <= 1'b1;
          end else if (pick_found) begin
            stored_q  <= wdata_lane[pick_idx];
            q_q       <= wdata_lane[pick_idx];
            grant_q   <= pick_onehot;
            ptr_q     <= ptr_next;
            q_valid_q <= 1'b1;
          end else begin
            grant_q <= '0;
          end
        end
        StForced: begin
          grant_q <= '0;
          if (force_en_i) begin
            q_q       <= force_val_i;
            q_valid_q <= 1'b1;
          end else begin
            // Release edge: no arbitration until the next edge.
            state_q <= StRun;
            if (RELEASE_KEEP != 0) begin
              stored_q <= force_val_i;
              q_q      <= force_val_i;
            end else begin
              q_q <= stored_q;
            end
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign q_o       = q_q;
  assign q_valid_o = q_valid_q;
  assign forced_o  = (state_q == StForced);

endmodule

// File: tb/tb_reg_override_arbiter.sv
// Bench for reg_override_arbiter: two instances (pre-force restore and keep-forced-value)
// share stimulus; expectations are queued at drive time and checked after the edge.
module tb_reg_override_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic           force_en;
  logic [W-1:0]   force_val;

  logic [N-1:0]   grant0, grant1;
  logic [W-1:0]   q0, q1;
  logic           qv0, qv1;
  logic           forced0, forced1;

  reg_override_arbiter #(
    .N(N), .W(W), .RELEASE_KEEP(0)
  ) dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .wdata_i    (wdata),
    .force_en_i (force_en),
    .force_val_i(force_val),
    .grant_o    (grant0),
    .q_o        (q0),
    .q_valid_o  (qv0),
    .forced_o   (forced0)
  );

  reg_override_arbiter #(
    .N(N), .W(W), .RELEASE_KEEP(1)
  ) dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .wdata_i    (wdata),
    .force_en_i (force_en),
    .force_val_i(force_val),
    .grant_o    (grant1),
    .q_o        (q1),
    .q_valid_o  (qv1),
    .forced_o   (forced1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [3:0]   req;
    logic [31:0]  wdata;
    logic         fe;
    logic [7:0]   fv;
    logic [3:0]   g;
    logic [7:0]   q_restore;
    logic [7:0]   q_keep;
    logic         qv;
    logic         fr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] Fair = {8'hD4, 8'hC3, 8'hB2, 8'hA1};

  task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] wd, input logic fe,
                     input logic [7:0] fv, input logic [3:0] g, input logic [7:0] qa,
                     input logic [7:0] qb, input logic qv, input logic fr);
    vec_t v;
    v.rst = r; v.req = rq; v.wdata = wd; v.fe = fe; v.fv = fv;
    v.g = g; v.q_restore = qa; v.q_keep = qb; v.qv = qv; v.fr = fr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; req = v.req; wdata = v.wdata; force_en = v.fe; force_val = v.fv;
  endtask

  task automatic compare(input vec_t e, input int idx);
    chk("grant_r", idx, 32'(grant0), 32'(e.g));
    chk("grant_k", idx, 32'(grant1), 32'(e.g));
    chk("q_r", idx, 32'(q0), 32'(e.q_restore));
    chk("q_k", idx, 32'(q1), 32'(e.q_keep));
    chk("qvalid_r", idx, 32'(qv0), 32'(e.qv));
    chk("qvalid_k", idx, 32'(qv1), 32'(e.qv));
    chk("forced_r", idx, 32'(forced0), 32'(e.fr));
    chk("forced_k", idx, 32'(forced1), 32'(e.fr));
  endtask

  initial begin
    logic [3:0] fair_g [4];
    logic [7:0] fair_q [4];
    logic [3:0] hreq;
    vec_t       v;
    vec_t       e;

    //   rst req      wdata                             fe fv     grant    qR     qK     qv fr
    add(1, 4'hF,    Fair,                             0, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 0);
    add(1, 4'hF,    Fair,                             0, 8'h00, 4'b0000, 8'h00, 8'h00, 0, 0);
    add(0, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00},     0, 8'h00, 4'b0100, 8'hA5, 8'hA5, 1, 0);
    add(0, 4'b0000, {8'h00, 8'hA5, 8'h00, 8'h00},     0, 8'h00, 4'b0000, 8'hA5, 8'hA5, 1, 0);
    add(0, 4'b1000, {8'h5A, 8'h00, 8'h00, 8'h00},     0, 8'h00, 4'b1000, 8'h5A, 8'h5A, 1, 0);
    // Fairness from ptr=0, each requester drops on its grant.
    add(0, 4'b1111, Fair,                             0, 8'h00, 4'b0001, 8'hA1, 8'hA1, 1, 0);
    add(0, 4'b1110, Fair,                             0, 8'h00, 4'b0010, 8'hB2, 8'hB2, 1, 0);
    add(0, 4'b1100, Fair,                             0, 8'h00, 4'b0100, 8'hC3, 8'hC3, 1, 0);
    add(0, 4'b1000, Fair,                             0, 8'h00, 4'b1000, 8'hD4, 8'hD4, 1, 0);
    add(0, 4'b0000, Fair,                             0, 8'h00, 4'b0000, 8'hD4, 8'hD4, 1, 0);
    // Requester holding req past its grant is masked for one edge.
    add(0, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h77},     0, 8'h00, 4'b0001, 8'h77, 8'h77, 1, 0);
    add(0, 4'b0001, {8'h00, 8'h00, 8'h00, 8'h66},     0, 8'h00, 4'b0000, 8'h77, 8'h77, 1, 0);
    add(0, 4'b0000, 32'h0,                            0, 8'h00, 4'b0000, 8'h77, 8'h77, 1, 0);
    // Force / release with req[1] pending.
    add(0, 4'b0010, {8'h00, 8'h00, 8'h3C, 8'h00},     0, 8'h00, 4'b0010, 8'h3C, 8'h3C, 1, 0);
    add(0, 4'b0000, 32'h0,                            0, 8'h00, 4'b0000, 8'h3C, 8'h3C, 1, 0);
    add(0, 4'b0010, {8'h00, 8'h00, 8'h99, 8'h00},     1, 8'h11, 4'b0000, 8'h11, 8'h11, 1, 1);
    add(0, 4'b0010, {8'h00, 8'h00, 8'h99, 8'h00},     1, 8'h22, 4'b0000, 8'h22, 8'h22, 1, 1);
    add(0, 4'b0010, {8'h00, 8'h00, 8'h99, 8'h00},     0, 8'h22, 4'b0000, 8'h3C, 8'h22, 1, 0);
    add(0, 4'b0010, {8'h00, 8'h00, 8'h99, 8'h00},     0, 8'h22, 4'b0010, 8'h99, 8'h99, 1, 0);
    add(0, 4'b0000, 32'h0,                            0, 8'h22, 4'b0000, 8'h99, 8'h99, 1, 0);
    // Reset in the middle of a force, then force still asserted.
    add(0, 4'b0000, 32'h0,                            1, 8'h22, 4'b0000, 8'h22, 8'h22, 1, 1);
    add(1, 4'b0000, 32'h0,                            1, 8'h22, 4'b0000, 8'h00, 8'h00, 0, 0);
    add(0, 4'b0000, 32'h0,                            1, 8'h22, 4'b0000, 8'h22, 8'h22, 1, 1);
    add(0, 4'b0000, 32'h0,                            0, 8'h22, 4'b0000, 8'h00, 8'h22, 1, 0);
    // Pointer came back to 0 after reset.
    add(0, 4'b1111, Fair,                             0, 8'h00, 4'b0001, 8'hA1, 8'hA1, 1, 0);
    add(0, 4'b0000, Fair,                             0, 8'h00, 4'b0000, 8'hA1, 8'hA1, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      compare(e, i);
    end

    // All four requesting with ptr=1: served 1,2,3,0, the last waiting exactly N cycles.
    fair_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fair_q = '{8'hB2, 8'hC3, 8'hD4, 8'hA1};
    hreq = 4'hF;
    for (int k = 0; k < 4; k++) begin
      v.rst = 0; v.req = hreq; v.wdata = Fair; v.fe = 0; v.fv = 8'h00;
      v.g = fair_g[k]; v.q_restore = fair_q[k]; v.q_keep = fair_q[k]; v.qv = 1; v.fr = 0;
      drive(v);
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      compare(e, 100 + k);
      hreq = hreq & ~fair_g[k];
    end
    v.req = 4'h0; v.g = 4'b0000;
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    compare(e, 104);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
